// File: rtl/nn_pkg.sv
// Shared types and default sizes for the layer-3 activation stage.
// Build option: RELU3_LEAKY_EN (leaky ReLU in relu3_act) - see relu3_act.sv.
package nn_pkg;

    localparam int unsigned NN_DATA_WIDTH    = 32;
    localparam int unsigned NN_ADDR_WIDTH    = 16;
    // Depth of relu3_memory; one pass covers exactly this many words.
    localparam int unsigned RELU3_NUM_ELEMS  = 32;
    localparam int unsigned RELU3_LEAK_SHIFT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } relu3_state_e;

endpackage

// File: rtl/relu3_act.sv
// Combinational activation for layer 3: plain ReLU, or leaky ReLU with an
// arithmetic right shift of LEAK_SHIFT when RELU3_LEAKY_EN is defined.
module relu3_act #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] act_c
);

`ifdef RELU3_LEAKY_EN
    localparam bit LEAKY_EN = 1'b1;
`else
    localparam bit LEAKY_EN = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] leak_c;

    // Sign-preserving shift; only selected for negative inputs in the leaky build.
    assign leak_c = DATA_WIDTH'($signed(x) >>> LEAK_SHIFT);

    assign act_c = !x[DATA_WIDTH-1] ? x : (LEAKY_EN ? leak_c : '0);

endmodule

// File: rtl/relu3_stage.sv
// Layer-3 activation sequencer: streams matmul3 output through relu3_act into
// relu3_memory and pulses done. Build option: RELU3_LEAKY_EN (via relu3_act).
module relu3_stage
    import nn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NN_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = NN_ADDR_WIDTH,
    parameter int unsigned NUM_ELEMS  = RELU3_NUM_ELEMS,
    parameter int unsigned LEAK_SHIFT = RELU3_LEAK_SHIFT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic                  dst_we,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] neg_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_ELEMS - 1);

    relu3_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] dst_addr_d;
    logic [DATA_WIDTH-1:0] dst_data_d;
    logic                  dst_we_d;
    logic                  busy_d;
    logic                  done_d;
    logic [ADDR_WIDTH-1:0] neg_count_d;
    logic [DATA_WIDTH-1:0] act_c;

    relu3_act #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_act (
        .x     (src_data),
        .act_c (act_c)
    );

    assign src_addr = idx_q;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dst_addr_d  = dst_addr;
        dst_data_d  = dst_data;
        dst_we_d    = 1'b0;
        done_d      = 1'b0;
        neg_count_d = neg_count;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    idx_d       = '0;
                    neg_count_d = '0;
                end
            end
            RUN: begin
                dst_we_d    = 1'b1;
                dst_addr_d  = idx_q;
                dst_data_d  = act_c;
                neg_count_d = neg_count + ADDR_WIDTH'(src_data[DATA_WIDTH-1]);
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy tracks the state being entered so it is high exactly in RUN and DRAIN.
        busy_d = (state_d == RUN) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            dst_addr  <= '0;
            dst_data  <= '0;
            dst_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            neg_count <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dst_addr  <= dst_addr_d;
            dst_data  <= dst_data_d;
            dst_we    <= dst_we_d;
            busy      <= busy_d;
            done      <= done_d;
            neg_count <= neg_count_d;
        end
    end

endmodule
